// File: rtl/mul_ctrl.sv
// mul_ctrl: multi-cycle sequencer around an external unsigned 32x32->64
// combinational multiplier, executing the RV32M MUL/MULH/MULHSU/MULHU ops.
// Operands are converted to magnitudes and held while the multiplier
// settles for LATENCY cycles. The product is then sign-corrected, the
// requested word is selected, and the result is held until consumed.
module mul_ctrl #(
  parameter int LATENCY = 2            // settle cycles, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int CW = 4;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Request context kept for the post-multiply correction.
  typedef struct packed {
    logic [1:0] op;
    logic       sa;
    logic       sb;
  } req_t;

  state_t          state, state_nxt;
  req_t            req;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            calc_end;
  logic            new_sa, new_sb;
  logic [63:0]     prod;
  logic [31:0]     res;

  assign accept   = in_valid & in_ready;
  assign calc_end = (state == CALC) && (cnt == '0);

  // Sign flags of the incoming request; MUL low word is sign-agnostic so it
  // always runs unsigned, MULHU likewise.
  always_comb begin
    new_sa = rs1[31] & ((op == OP_MULH) | (op == OP_MULHSU));
    new_sb = rs2[31] &  (op == OP_MULH);
  end

  // Correct the unsigned magnitude product and pick the requested word.
  always_comb begin
    prod = (req.sa ^ req.sb) ? (~mul_p + 64'd1) : mul_p;
    res  = (req.op == OP_MUL) ? prod[31:0] : prod[63:32];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush overrides everything, including a pending result.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept)   state_nxt = CALC;
        CALC: if (calc_end) state_nxt = DONE;
        DONE: if (out_ready) state_nxt = accept ? CALC : IDLE;
        default:            state_nxt = IDLE;
      endcase
    end
  end

  // Handshake outputs: out_valid is a pure state decode, in_ready never
  // looks at in_valid.
  always_comb begin
    out_valid = (state == DONE);
    in_ready  = ~flush & ((state == IDLE) | ((state == DONE) & out_ready));
  end

  // Operand capture, settle countdown and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else if (accept) begin
      req.op   <= op;
      req.sa   <= new_sa;
      req.sb   <= new_sb;
      mul_a    <= new_sa ? (~rs1 + 32'd1) : rs1;
      mul_b    <= new_sb ? (~rs2 + 32'd1) : rs2;
      cnt      <= CW'(LATENCY - 1);
    end else if ((state == CALC) && !flush) begin
      if (cnt != '0) cnt      <= cnt - 1'b1;
      else           out_data <= res;
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: an ideal multiplier model feeds mul_p, a monitor
// tracks an abstract request/response model, and a scoreboard queue holds
// expected results computed with plain 64-bit arithmetic.
module tb_mul_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [1:0]  op;
  logic [31:0] rs1, rs2, mul_a, mul_b, out_data;
  logic [63:0] mul_p;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int hs_cnt = 0;

  logic [31:0] sb_q[$];
  int          acc_log[$];
  logic        have_req = 1'b0;
  int          acc_cyc  = 0;
  logic        eov, eir;

  mul_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .flush(flush),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // the external combinational multiplier
  assign mul_p = {32'd0, mul_a} * {32'd0, mul_b};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  // RV32M semantics by extending operands to 64 bits and multiplying.
  function automatic logic [31:0] ref_mul(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    longint x, y;
    logic [63:0] p;
    x = (o == 2'b01 || o == 2'b10) ? longint'($signed(a)) : longint'({32'd0, a});
    y = (o == 2'b01) ? longint'($signed(b)) : longint'({32'd0, b});
    p = 64'(x * y);
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor/scoreboard: one request in flight, result visible LAT cycles
  // after acceptance, consumed on out_ready, dropped on flush or reset.
  always @(negedge clk) begin
    if (rst) begin
      have_req = 1'b0;
      sb_q.delete();
    end else begin
      eov = have_req && ((cyc - acc_cyc) >= LAT);
      eir = !flush && (!have_req || (eov && out_ready));
      chk("out_valid", {63'd0, out_valid}, {63'd0, eov});
      chk("in_ready", {63'd0, in_ready}, {63'd0, eir});
      if (eov) chk("out_data", {32'd0, out_data}, {32'd0, sb_q[0]});
      if (flush) begin
        have_req = 1'b0;
        sb_q.delete();
      end else begin
        if (eov && out_ready) begin
          void'(sb_q.pop_front());
          have_req = 1'b0;
          hs_cnt++;
        end
        if (in_valid && eir) begin
          sb_q.push_back(ref_mul(op, rs1, rs2));
          have_req = 1'b1;
          acc_cyc  = cyc + 1;
          acc_log.push_back(cyc + 1);
        end
      end
    end
  end

  task automatic drive(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b;
  endtask

  // Present a request and hold it until the accepting edge has passed.
  task automatic issue(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    bit ok = 0;
    drive(o, a, b);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready && !flush) ok = 1;
    end
    if (!ok) fail_now("accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1;
    end
    if (!ok) fail_now("out_valid");
  endtask

  task automatic run(string nm, logic [1:0] o, logic [31:0] a, logic [31:0] b, logic [31:0] g);
    out_ready = 1'b1;
    issue(o, a, b);
    wait_out();
    chk(nm, {32'd0, out_data}, {32'd0, g});
    @(posedge clk); #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 60 && have_req; i++) @(negedge clk);
    if (have_req) fail_now("drain");
    @(posedge clk); #1;
  endtask

  initial begin
    int h0;
    bit acc;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = 2'b00; rs1 = '0; rs2 = '0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_mul_a", {32'd0, mul_a}, 64'd0);
    chk("rst_mul_b", {32'd0, mul_b}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // signed, unsigned and mixed corner cases
    run("mul_7_m3",      2'b00, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run("mulh_min_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run("mulh_m1_m1",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run("mulhu_max",     2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("mulhsu_m1_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("mulhsu_2_min",  2'b10, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001);

    // backpressure: result held for 5 cycles, then exactly one handshake
    out_ready = 1'b0;
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out();
    h0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", {32'd0, out_data}, 64'hFFFF_FFFE);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("bp_handshakes", 64'(hs_cnt - h0), 64'd1);
    @(posedge clk); #1;

    // back-to-back with out_ready high: accepts every LAT+1 cycles
    acc_log.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(2'(k), $urandom, $urandom);
      acc = 0;
      for (int i = 0; i < 20 && !acc; i++) begin
        @(negedge clk);
        if (in_ready) acc = 1;
      end
      if (!acc) fail_now("b2b_accept");
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_count", 64'(acc_log.size()), 64'd3);
    if (acc_log.size() == 3) begin
      chk("b2b_gap0", 64'(acc_log[1] - acc_log[0]), 64'(LAT + 1));
      chk("b2b_gap1", 64'(acc_log[2] - acc_log[1]), 64'(LAT + 1));
    end

    // flush in CALC with a competing request
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    flush = 1'b1;
    drive(2'b11, 32'hDEAD_BEEF, 32'h1);
    @(negedge clk);
    chk("flush_calc_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_calc_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    run("after_flush_calc", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

    // flush in DONE with out_ready and in_valid also high
    out_ready = 1'b0;
    issue(2'b11, 32'h8000_0000, 32'h4);
    wait_out();
    @(posedge clk); #1;
    flush = 1'b1; out_ready = 1'b1;
    drive(2'b00, 32'd5, 32'd6);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_done_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    run("after_flush_done", 2'b10, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);

    // asynchronous reset in the middle of CALC
    issue(2'b00, 32'd9, 32'd9);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk("rst_calc_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_calc_in_ready", {63'd0, in_ready}, 64'd1);
    end
    @(posedge clk); #1;

    // randomized traffic with backpressure and occasional flush
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        op  = 2'($urandom_range(0, 3));
        rs1 = pick();
        rs2 = pick();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
